// File: rtl/muldivmod_seq.sv
// muldivmod_seq: iterative multiply / divide-with-remainder unit, one bit per clock.
// Multiply is shift-add (W steps, multiplier LSB first). Divide is restoring
// division (2W steps, dividend MSB first). Signed operands are converted to
// magnitudes at issue, and the signs are reapplied on the final edge.
module muldivmod_seq #(
   parameter int unsigned W = 10
) (
   input  logic           t,
   input  logic           rn,
   input  logic           go,
   input  logic           m,
   input  logic           s,
   input  logic [2*W-1:0] a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] p,
   output logic [W-1:0]   r,
   output logic           z
);

   localparam int unsigned CW = $clog2(2*W+1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           mode_q, mode_d;     // 0 = multiply, 1 = divide
   logic           neg_q, neg_d;       // product / quotient sign
   logic           rneg_q, rneg_d;     // remainder sign (dividend sign)
   logic           zero_q, zero_d;     // divisor was zero at issue
   logic [W-1:0]   alo_q, alo_d;       // raw a[W-1:0], the remainder on divide-by-zero
   // x: product accumulator (multiply) or dividend-in / quotient-out shift register (divide)
   logic [2*W-1:0] x_q, x_d;
   // y: multiplicand magnitude (multiply) or divisor magnitude (divide)
   logic [W-1:0]   y_q, y_d;
   // u: multiplier shifting right (multiply) or partial remainder (divide)
   logic [W:0]     u_q, u_d;
   logic [2*W-1:0] p_q, p_d;
   logic [W-1:0]   r_q, r_d;
   logic           z_q, z_d;

   // Datapath and issue temporaries
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_x;
   logic [W:0]     div_sh;
   logic [W+1:0]   div_diff;
   logic           div_ge;
   logic [2*W-1:0] div_x;
   logic [W:0]     div_u;
   logic [2*W-1:0] step_x, step_x_neg;
   logic [W:0]     step_u;
   logic [W-1:0]   rem_mag, rem_neg;
   logic [W-1:0]   a_lo, a_lo_neg, a_lo_mag;
   logic [2*W-1:0] a_neg, a_mag;
   logic [W-1:0]   b_neg, b_mag;

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign p    = p_q;
   assign r    = r_q;
   assign z    = z_q;

   // One iteration step for both operations, plus issue and final sign fixup
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      zero_d  = zero_q;
      alo_d   = alo_q;
      x_d     = x_q;
      y_d     = y_q;
      u_d     = u_q;
      p_d     = p_q;
      r_d     = r_q;
      z_d     = z_q;

      // Shift-add: add the multiplicand into the top half, then shift the
      // whole accumulator right so each multiplier bit lands at its weight.
      mul_sum = {1'b0, x_q[2*W-1:W]} + {1'b0, (u_q[0] ? y_q : '0)};
      mul_x   = {mul_sum, x_q[W-1:1]};

      // Restoring divide: bring in the next dividend bit, trial-subtract.
      div_sh   = {u_q[W-1:0], x_q[2*W-1]};
      div_diff = {1'b0, div_sh} - {2'b00, y_q};
      div_ge   = ~div_diff[W+1];
      div_u    = div_ge ? div_diff[W:0] : div_sh;
      div_x    = {x_q[2*W-2:0], div_ge};

      step_x     = mode_q ? div_x : mul_x;
      step_u     = mode_q ? div_u : (u_q >> 1);
      step_x_neg = -step_x;
      rem_mag    = step_u[W-1:0];
      rem_neg    = -rem_mag;

      a_lo     = a[W-1:0];
      a_lo_neg = -a_lo;
      a_lo_mag = (s && a_lo[W-1]) ? a_lo_neg : a_lo;
      a_neg    = -a;
      a_mag    = (s && a[2*W-1]) ? a_neg : a;
      b_neg    = -b;
      b_mag    = (s && b[W-1]) ? b_neg : b;

      case (state_q)
         S_RUN: begin
            x_d   = step_x;
            u_d   = step_u;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
               if (!mode_q) begin
                  p_d = neg_q ? step_x_neg : step_x;
                  r_d = '0;
                  z_d = 1'b0;
               end else if (zero_q) begin
                  p_d = '1;
                  r_d = alo_q;
                  z_d = 1'b1;
               end else begin
                  p_d = neg_q ? step_x_neg : step_x;
                  r_d = rneg_q ? rem_neg : rem_mag;
                  z_d = 1'b0;
               end
            end
         end
         S_DONE: begin
            if (!go) state_d = S_IDLE;
         end
         default: ;
      endcase

      // Issue is shared by IDLE and DONE so a go during done starts at once.
      if (state_q != S_RUN && go) begin
         state_d = S_RUN;
         mode_d  = m;
         alo_d   = a_lo;
         zero_d  = m && (b == '0);
         rneg_d  = s && m && a[2*W-1];
         neg_d   = s && (m ? (a[2*W-1] ^ b[W-1]) : (a[W-1] ^ b[W-1]));
         if (m) begin
            x_d   = a_mag;
            y_d   = b_mag;
            u_d   = '0;
            cnt_d = CW'(2*W);
         end else begin
            x_d   = '0;
            y_d   = a_lo_mag;
            u_d   = {1'b0, b_mag};
            cnt_d = CW'(W);
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge t or negedge rn) begin
      if (!rn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         zero_q  <= 1'b0;
         alo_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         u_q     <= '0;
         p_q     <= '0;
         r_q     <= '0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         zero_q  <= zero_d;
         alo_q   <= alo_d;
         x_q     <= x_d;
         y_q     <= y_d;
         u_q     <= u_d;
         p_q     <= p_d;
         r_q     <= r_d;
         z_q     <= z_d;
      end
   end

endmodule

// File: tb/tb_muldivmod_seq.sv
// Bench for muldivmod_seq (W=10): directed cases plus random operations,
// checked against an arithmetic reference model.
module tb_muldivmod_seq;

   localparam int W = 10;

   logic          t, rn, go, m, s;
   logic [19:0]   a, p;
   logic [9:0]    b, r;
   logic          busy, done, z;

   int n_assert = 0;
   int n_fail   = 0;

   muldivmod_seq #(.W(W)) dut (
      .t(t), .rn(rn), .go(go), .m(m), .s(s), .a(a), .b(b),
      .busy(busy), .done(done), .p(p), .r(r), .z(z)
   );

   initial t = 1'b0;
   always #5 t = ~t;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands as the user sees them.
   function automatic void model(input bit mm, input bit ss, input logic [19:0] aa,
                                 input logic [9:0] bb, output logic [19:0] ep,
                                 output logic [9:0] er, output logic ez);
      longint x, y, q, rm;
      logic [9:0] alo;
      alo = aa[9:0];
      ep = '0; er = '0; ez = 1'b0;
      if (!mm) begin
         x  = ss ? longint'($signed(alo)) : longint'(alo);
         y  = ss ? longint'($signed(bb))  : longint'(bb);
         q  = x * y;
         ep = q[19:0];
      end else if (bb == 10'd0) begin
         ep = '1; er = alo; ez = 1'b1;
      end else begin
         x  = ss ? longint'($signed(aa)) : longint'(aa);
         y  = ss ? longint'($signed(bb)) : longint'(bb);
         q  = x / y;
         rm = x % y;
         ep = q[19:0];
         er = rm[9:0];
      end
   endfunction

   // Called at the negedge after the go edge; returns at the negedge where done is seen.
   task automatic wait_done(input string tag, input int lat, input int midgo_at);
      int n = 0;
      bit busy_bad = 1'b0;
      while (done !== 1'b1 && n < 100) begin
         if (busy !== 1'b1) busy_bad = 1'b1;
         @(negedge t);
         n++;
         if (n == midgo_at) go = 1'b1;
         else if (n == midgo_at + 1) go = 1'b0;
      end
      check({tag, "_latency"}, n, lat);
      check({tag, "_busy_run"}, busy_bad, 0);
      check({tag, "_busy_done"}, busy, 0);
   endtask

   task automatic run_op(input string tag, input bit mm, input bit ss, input logic [19:0] aa,
                         input logic [9:0] bb, input int midgo_at);
      logic [19:0] ep;
      logic [9:0]  er;
      logic        ez;
      model(mm, ss, aa, bb, ep, er, ez);
      @(negedge t);
      go = 1'b1; m = mm; s = ss; a = aa; b = bb;
      @(negedge t);
      go = 1'b0;
      a = 20'($urandom); b = 10'($urandom); m = 1'($urandom); s = 1'($urandom);
      wait_done(tag, mm ? 2*W : W, midgo_at);
      check({tag, "_p"}, p, ep);
      check({tag, "_r"}, r, er);
      check({tag, "_z"}, z, ez);
   endtask

   initial begin
      logic [19:0] ep1, ep2;
      logic [9:0]  er1, er2;
      logic        ez1, ez2;
      int done_seen;

      rn = 1'b0; go = 1'b0; m = 1'b0; s = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge t);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_p", p, 0);
      check("rst_r", r, 0);
      check("rst_z", z, 0);
      rn = 1'b1;

      // Directed cases
      run_op("umul", 1'b0, 1'b0, 20'd517, 10'd141, -1);
      check("umul_const", p, 20'd72897);
      run_op("udiv_midgo", 1'b1, 1'b0, 20'd72897, 10'd139, 4);
      check("udiv_const_p", p, 20'd524);
      check("udiv_const_r", r, 10'd61);
      run_op("smul", 1'b0, 1'b1, 20'h003FD, 10'd5, -1);
      check("smul_const", p, 20'hFFFF1);
      run_op("sdiv", 1'b1, 1'b1, 20'hEE33F, 10'd139, -1);
      check("sdiv_const_p", p, 20'hFFDF4);
      check("sdiv_const_r", r, 10'h3C3);
      run_op("sdiv_small", 1'b1, 1'b1, 20'd7, 10'h3FE, -1);
      check("sdiv_small_p", p, 20'hFFFFD);
      check("sdiv_small_r", r, 10'd1);
      run_op("sovf", 1'b1, 1'b1, 20'h80000, 10'h3FF, -1);
      check("sovf_p", p, 20'h80000);
      run_op("div0", 1'b1, 1'b0, 20'd1234, 10'd0, -1);
      check("div0_r", r, 10'd210);
      run_op("sdiv0", 1'b1, 1'b1, 20'hFFC01, 10'd0, -1);

      // Asynchronous reset in the middle of a divide
      @(negedge t);
      go = 1'b1; m = 1'b1; s = 1'b0; a = 20'd99999; b = 10'd7;
      @(negedge t);
      go = 1'b0;
      repeat (4) @(negedge t);
      #2 rn = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_p", p, 0);
      check("arst_r", r, 0);
      check("arst_z", z, 0);
      repeat (2) @(negedge t);
      rn = 1'b1;
      done_seen = 0;
      repeat (30) begin
         @(negedge t);
         if (done === 1'b1) done_seen++;
      end
      check("arst_no_done", done_seen, 0);
      check("arst_idle_busy", busy, 0);

      run_op("div0_after_rst", 1'b1, 1'b0, 20'd1234, 10'd0, -1);
      run_op("mul_clears_z", 1'b0, 1'b0, 20'd3, 10'd4, -1);

      // Back-to-back: go held high through done
      model(1'b0, 1'b0, 20'd300, 10'd700, ep1, er1, ez1);
      model(1'b1, 1'b1, 20'hF0000, 10'd77, ep2, er2, ez2);
      @(negedge t);
      go = 1'b1; m = 1'b0; s = 1'b0; a = 20'd300; b = 10'd700;
      @(negedge t);
      wait_done("b2b1", W, -1);
      check("b2b1_p", p, ep1);
      check("b2b1_r", r, er1);
      m = 1'b1; s = 1'b1; a = 20'hF0000; b = 10'd77;
      @(negedge t);
      check("b2b_gap_done", done, 0);
      check("b2b_gap_busy", busy, 1);
      check("b2b_hold_p", p, ep1);
      go = 1'b0;
      wait_done("b2b2", 2*W, -1);
      check("b2b2_p", p, ep2);
      check("b2b2_r", r, er2);
      check("b2b2_z", z, ez2);

      // Random operations
      for (int i = 0; i < 30; i++) begin
         run_op("rnd", 1'($urandom), 1'($urandom), 20'($urandom),
                ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
